fp_int_acc_seq: RTL and testbench
=================================

// Module: fp_int_acc_seq
// PURPOSE
//  Sequencer for the fp-to-fixed accumulate datapath (fp_int_acc).
//  Accepts a vector of cfg_len fp terms (sign, exp, frac) over a valid/ready stream.
//  Issues one datapath operation per term and feeds the running fixed-point sum back as the accumulator operand.
//  Returns the final sum on a valid/ready result port.
//  Sits between the term producer (decoder/MAC front end) and the single shared datapath instance.
// PARAMETERS
//  EXP_W    5   exponent width (term_exp, cfg_exp_set, acc_exp_*)
//  FRAC_W   14  term fraction width
//  ACC_W    32  fixed-point accumulator width
//  LEN_W    8   width of cfg_len / term counter
//  TIMEOUT  8   max WAIT cycles for a datapath done edge before error
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, asynchronous, active-low
//  cmd_start      in   1       begin a vector (sampled in IDLE only)
//  cfg_len        in   LEN_W   number of terms, latched on cmd_start
//  cfg_exp_set    in   EXP_W   target exponent, latched on cmd_start
//  busy           out  1       1 in any state except IDLE
//  term_valid     in   1       term available
//  term_ready     out  1       term accepted when valid&ready
//  term_sign      in   1       1 = subtract term
//  term_exp       in   EXP_W   term exponent
//  term_frac      in   FRAC_W  term fraction
//  acc_start      out  1       datapath start, one-cycle pulse
//  acc_sign       out  1       datapath sign operand
//  acc_exp_set    out  EXP_W   datapath target exponent
//  acc_fixed_acc  out  ACC_W   running sum to datapath
//  acc_exp_in     out  EXP_W   datapath term exponent
//  acc_frac_in    out  FRAC_W  datapath term fraction
//  acc_done       in   1       datapath done level
//  acc_fixed_out  in   ACC_W   datapath result
//  res_valid      out  1       result available
//  res_ready      in   1       result consumed when valid&ready
//  res_fixed      out  ACC_W   final sum
//  res_exp        out  EXP_W   exponent of res_fixed (= latched cfg_exp_set)
//  res_err        out  1       1 = vector aborted on datapath timeout
// BEHAVIOUR
//  Reset: state=IDLE. Every output, sum, counter, done_q and timer = 0. Applies mid-operation too: no partial result is emitted.
//  FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
//  IDLE: cmd_start=1 latches cfg_len and cfg_exp_set, sum<=0, cnt<=0, err<=0.
//   Next state is DONE if cfg_len==0, else LOAD.
//  LOAD: term_ready=1. On valid&ready, register sign/exp/frac into acc_* operands -> ISSUE.
//   No term_valid: stay, no acc_start.
//  ISSUE: acc_start=1 for exactly 1 cycle; acc_fixed_acc=sum -> WAIT.
//  WAIT: done edge = acc_done & ~done_q, where done_q is acc_done registered every cycle.
//   On edge: sum<=acc_fixed_out, cnt<=cnt+1; then DONE if cnt+1==len, else LOAD.
//   timer counts WAIT cycles; if it reaches TIMEOUT with no edge: err<=1 -> DONE (sum keeps partial value).
//  DONE: res_valid=1, res_fixed=sum, res_exp=latched exp_set, res_err=err, all held stable until res_ready.
//   On valid&ready -> IDLE, res_valid=0 the next cycle.
//  acc_sign/acc_exp_in/acc_frac_in/acc_exp_set/acc_fixed_acc held constant from ISSUE through end of WAIT.
//   The datapath samples sign a cycle late; operands must not move.
//  Datapath contract: done drops within 1 cycle of acc_start and rises >=1 cycle later.
//   Nominal per-term cost: LOAD 1 + ISSUE 1 + WAIT 2 = 4 cycles with term_valid held high.
//  Arithmetic: sum is ACC_W two's-complement and wraps modulo 2^ACC_W; no saturation or overflow flag.
//  cmd_start outside IDLE is ignored. term_ready=0 outside LOAD. Term beats beyond cfg_len are not consumed.
//  acc_done edges outside WAIT are ignored; done_q still tracks acc_done.
// TESTING
//  1 len=3, exp_set=10, terms (+,10,100), (+,12,3), (-,9,8) with reference datapath model
//    -> res_fixed=108, res_exp=10, res_err=0, exactly 3 acc_start pulses.
//  2 len=0 -> res_valid 1 cycle after cmd_start, res_fixed=0, no acc_start, no term_ready.
//  3 len=2, acc_done stuck 0, TIMEOUT=8 -> after 8 WAIT cycles res_valid=1, res_err=1, res_fixed=0.
//    Only 1 term consumed.
//  4 res_ready low 5 cycles in DONE -> res_valid/res_fixed stable, term_ready=0, cmd_start ignored.
//  5 term_valid low 3 cycles in LOAD -> no acc_start during gap; final sum equals the no-gap run.
//  6 rst asserted in WAIT of term 2 -> all outputs 0 immediately.
//    A following cmd_start len=1, term (+,10,5) gives res_fixed=5.

Source files
------------

// File: rtl/fp_int_acc_seq.sv
// Sequencer for the shared fp_int_acc datapath: streams cfg_len fp terms through it,
// feeding the running fixed-point sum back as the accumulator operand, then returns the sum.
module fp_int_acc_seq #(
  parameter int EXP_W   = 5,
  parameter int FRAC_W  = 14,
  parameter int ACC_W   = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [EXP_W-1:0]  cfg_exp_set,
  output logic              busy,
  input  logic              term_valid,
  output logic              term_ready,
  input  logic              term_sign,
  input  logic [EXP_W-1:0]  term_exp,
  input  logic [FRAC_W-1:0] term_frac,
  output logic              acc_start,
  output logic              acc_sign,
  output logic [EXP_W-1:0]  acc_exp_set,
  output logic [ACC_W-1:0]  acc_fixed_acc,
  output logic [EXP_W-1:0]  acc_exp_in,
  output logic [FRAC_W-1:0] acc_frac_in,
  input  logic              acc_done,
  input  logic [ACC_W-1:0]  acc_fixed_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_fixed,
  output logic [EXP_W-1:0]  res_exp,
  output logic              res_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_next;
  logic [EXP_W-1:0] exp_set;
  logic [ACC_W-1:0] sum;
  logic [TMR_W-1:0] timer;
  logic             err;
  logic             done_q;
  logic             done_edge;

  assign cnt_next  = cnt + CNT_ONE;
  assign done_edge = acc_done & ~done_q;

  // The latched exponent and the running sum/error double as the result port.
  assign acc_exp_set = exp_set;
  assign res_exp     = exp_set;
  assign res_fixed   = sum;
  assign res_err     = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      len           <= '0;
      cnt           <= '0;
      exp_set       <= '0;
      sum           <= '0;
      timer         <= '0;
      err           <= 1'b0;
      done_q        <= 1'b0;
      busy          <= 1'b0;
      term_ready    <= 1'b0;
      acc_start     <= 1'b0;
      acc_sign      <= 1'b0;
      acc_fixed_acc <= '0;
      acc_exp_in    <= '0;
      acc_frac_in   <= '0;
      res_valid     <= 1'b0;
    end else begin
      done_q <= acc_done;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            len     <= cfg_len;
            exp_set <= cfg_exp_set;
            sum     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            if (cfg_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state      <= LOAD;
              term_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (term_valid) begin
            acc_sign      <= term_sign;
            acc_exp_in    <= term_exp;
            acc_frac_in   <= term_frac;
            acc_fixed_acc <= sum;
            term_ready    <= 1'b0;
            acc_start     <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          acc_start <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        // Operands stay frozen here; the datapath samples sign one cycle late.
        WAIT: begin
          if (done_edge) begin
            sum <= acc_fixed_out;
            cnt <= cnt_next;
            if (cnt_next == len) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state      <= LOAD;
              term_ready <= 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            err       <= 1'b1;
            state     <= DONE;
            res_valid <= 1'b1;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_acc_seq.sv
// Self-checking bench for fp_int_acc_seq: a behavioural fp_int_acc datapath model,
// a directed vector table, a reset-abort sequence and randomized vectors vs. a reference sum.
module tb_fp_int_acc_seq;

  localparam int MAX_CYC = 300;
  localparam int NV      = 9;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [13:0] frac;
  } term_t;

  typedef struct packed {
    logic [7:0]      len;
    logic [4:0]      es;
    int              nterms;
    term_t [5:0]     terms;
    int              gap;
    int              stuck_at;
    int              rdy_delay;
    int              exp_lat;
    logic [31:0]     exp_fixed;
    logic            exp_err;
    int              exp_consumed;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [4:0]  cfg_exp_set = '0;
  logic        busy;
  logic        term_valid = 1'b0;
  logic        term_ready;
  logic        term_sign = 1'b0;
  logic [4:0]  term_exp = '0;
  logic [13:0] term_frac = '0;
  logic        acc_start;
  logic        acc_sign;
  logic [4:0]  acc_exp_set;
  logic [31:0] acc_fixed_acc;
  logic [4:0]  acc_exp_in;
  logic [13:0] acc_frac_in;
  logic        acc_done = 1'b1;
  logic [31:0] acc_fixed_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_fixed;
  logic [4:0]  res_exp;
  logic        res_err;

  int n_cmp = 0;
  int n_bad = 0;

  fp_int_acc_seq dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cfg_len(cfg_len), .cfg_exp_set(cfg_exp_set),
    .busy(busy), .term_valid(term_valid), .term_ready(term_ready), .term_sign(term_sign),
    .term_exp(term_exp), .term_frac(term_frac), .acc_start(acc_start), .acc_sign(acc_sign),
    .acc_exp_set(acc_exp_set), .acc_fixed_acc(acc_fixed_acc), .acc_exp_in(acc_exp_in),
    .acc_frac_in(acc_frac_in), .acc_done(acc_done), .acc_fixed_out(acc_fixed_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_fixed(res_fixed), .res_exp(res_exp),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Value of one fp term scaled to the target exponent: frac * 2^(exp - exp_set), truncated.
  function automatic logic [31:0] term_value(input logic s, input logic [4:0] e,
                                             input logic [4:0] es, input logic [13:0] f);
    longint d;
    longint mag;
    d = longint'(e) - longint'(es);
    if (d >= 0) mag = longint'(f) * (longint'(1) << d);
    else        mag = longint'(f) / (longint'(1) << (-d));
    if (s) mag = -mag;
    return mag[31:0];
  endfunction

  // Datapath model: done drops on start, rises dp_lat cycles later unless stuck.
  int   dp_lat = 1;
  int   dp_cnt = 0;
  logic dp_stuck = 1'b0;
  logic dp_stuck_cur = 1'b0;
  logic rand_lat = 1'b0;

  always @(posedge clk) begin
    if (acc_start) begin
      acc_done     <= 1'b0;
      dp_cnt       <= dp_lat;
      dp_stuck_cur <= dp_stuck;
    end else if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1 && !dp_stuck_cur) begin
        acc_done      <= 1'b1;
        acc_fixed_out <= acc_fixed_acc + term_value(acc_sign, acc_exp_in, acc_exp_set, acc_frac_in);
      end
    end
  end

  int   mon_consumed = 0;
  int   mon_starts = 0;
  int   pulse_viol = 0;
  logic start_q = 1'b0;

  always @(posedge clk) begin
    if (term_valid && term_ready) mon_consumed = mon_consumed + 1;
    if (acc_start) mon_starts = mon_starts + 1;
    if (acc_start && start_q) pulse_viol = pulse_viol + 1;
    start_q = acc_start;
  end

  logic        got_res, got_abort, gap_viol, saw_ready, got_err;
  logic [31:0] got_fixed;
  logic [4:0]  got_exp;
  int          got_lat, got_consumed, got_starts;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic term_t mk_term(input logic s, input logic [4:0] e, input logic [13:0] f);
    term_t t;
    t.sign = s;
    t.exp  = e;
    t.frac = f;
    return t;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] len, input logic [4:0] es, input int gap,
                                  input int stuck_at, input int rdy, input int lat,
                                  input logic [31:0] fixed, input logic err, input int consumed);
    vec_t v;
    v = '0;
    v.len          = len;
    v.es           = es;
    v.nterms       = (len == 8'd0) ? 1 : int'(len) + 1;
    v.gap          = gap;
    v.stuck_at     = stuck_at;
    v.rdy_delay    = rdy;
    v.exp_lat      = lat;
    v.exp_fixed    = fixed;
    v.exp_err      = err;
    v.exp_consumed = consumed;
    return v;
  endfunction

  // Runs one vector; abort_at >= 0 asserts reset in WAIT after that many issued terms.
  task automatic applyStimulus(input vec_t v, input int abort_at);
    int   cyc, idx, last_idx, gap_left, c0, s0;
    logic stop;
    got_res = 1'b0; got_abort = 1'b0; gap_viol = 1'b0; saw_ready = 1'b0;
    got_fixed = '0; got_exp = '0; got_err = 1'b0; got_lat = 0;
    c0 = mon_consumed;
    s0 = mon_starts;
    dp_stuck = 1'b0;
    @(negedge clk);
    cmd_start = 1'b1; cfg_len = v.len; cfg_exp_set = v.es; term_valid = 1'b0;
    @(negedge clk);
    cmd_start = 1'b0; cfg_len = 8'($urandom); cfg_exp_set = 5'($urandom);
    gap_left = v.gap; last_idx = 0; cyc = 1; stop = 1'b0;
    while (!stop) begin
      idx = mon_consumed - c0;
      if (term_ready) saw_ready = 1'b1;
      if (res_valid) begin
        got_res = 1'b1; got_lat = cyc; got_fixed = res_fixed; got_exp = res_exp; got_err = res_err;
        stop = 1'b1;
      end else if (abort_at >= 0 && (mon_starts - s0) == abort_at && !acc_start && !term_ready) begin
        rst = 1'b0; got_abort = 1'b1; stop = 1'b1;
      end else if (cyc >= MAX_CYC) begin
        stop = 1'b1;
      end else begin
        if (idx != last_idx) begin gap_left = v.gap; last_idx = idx; end
        dp_stuck = (v.stuck_at >= 0) && ((mon_starts - s0) >= v.stuck_at);
        if (rand_lat) dp_lat = int'($urandom_range(1, 3));
        if (term_ready && gap_left > 0) begin
          term_valid = 1'b0;
          gap_left--;
          if (acc_start) gap_viol = 1'b1;
        end else if (idx < v.nterms) begin
          term_valid = 1'b1;
          {term_sign, term_exp, term_frac} = v.terms[idx];
        end else begin
          term_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (got_res) begin
      for (int k = 0; k < v.rdy_delay; k++) begin
        cmd_start = 1'b1; cfg_len = 8'd3; cfg_exp_set = ~v.es;
        @(negedge clk);
        checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
        checkOutput("hold_res_fixed", res_fixed, v.exp_fixed);
        checkOutput("hold_res_exp", 32'(res_exp), 32'(v.es));
        checkOutput("hold_term_ready", 32'(term_ready), 32'd0);
      end
      cmd_start = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; term_valid = 1'b0;
      checkOutput("release_res_valid", 32'(res_valid), 32'd0);
      checkOutput("release_busy", 32'(busy), 32'd0);
    end else if (!got_abort) begin
      checkOutput("result_wait_expired", 32'd0, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    term_valid = 1'b0;
    got_consumed = mon_consumed - c0;
    got_starts   = mon_starts - s0;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, "_res_valid"}, 32'(got_res), 32'd1);
    if (got_res) begin
      checkOutput({tag, "_res_fixed"}, got_fixed, v.exp_fixed);
      checkOutput({tag, "_res_exp"}, 32'(got_exp), 32'(v.es));
      checkOutput({tag, "_res_err"}, 32'(got_err), 32'(v.exp_err));
      if (v.exp_lat > 0) checkOutput({tag, "_latency"}, got_lat, v.exp_lat);
    end
    checkOutput({tag, "_consumed"}, got_consumed, v.exp_consumed);
    checkOutput({tag, "_acc_starts"}, got_starts, v.exp_consumed);
    checkOutput({tag, "_term_ready_seen"}, 32'(saw_ready), 32'(v.len != 8'd0));
    checkOutput({tag, "_start_in_gap"}, 32'(gap_viol), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t        vecs[NV];
  vec_t        v;
  logic [31:0] acc;
  int          e;

  initial begin
    // Directed table: len, exp_set, gap, stuck_at, ready delay, latency, sum, err, consumed.
    vecs[0] = mk_vec(8'd3, 5'd10, 0, -1, 0, 13, 32'd108, 1'b0, 3);
    vecs[0].terms[0] = mk_term(1'b0, 5'd10, 14'd100);
    vecs[0].terms[1] = mk_term(1'b0, 5'd12, 14'd3);
    vecs[0].terms[2] = mk_term(1'b1, 5'd9, 14'd8);
    vecs[1] = mk_vec(8'd0, 5'd7, 0, -1, 0, 1, 32'd0, 1'b0, 0);
    vecs[1].terms[0] = mk_term(1'b0, 5'd7, 14'd9);
    vecs[2] = mk_vec(8'd2, 5'd10, 0, 0, 0, 11, 32'd0, 1'b1, 1);
    vecs[2].terms[0] = mk_term(1'b0, 5'd10, 14'd100);
    vecs[2].terms[1] = mk_term(1'b0, 5'd10, 14'd1);
    vecs[3] = mk_vec(8'd2, 5'd3, 0, -1, 5, 9, 32'd46, 1'b0, 2);
    vecs[3].terms[0] = mk_term(1'b0, 5'd3, 14'd50);
    vecs[3].terms[1] = mk_term(1'b1, 5'd5, 14'd1);
    vecs[4] = vecs[0];
    vecs[4].gap = 3;
    vecs[4].exp_lat = 22;
    vecs[5] = mk_vec(8'd2, 5'd10, 0, 1, 0, 15, 32'd14, 1'b1, 2);
    vecs[5].terms[0] = mk_term(1'b0, 5'd11, 14'd7);
    vecs[5].terms[1] = mk_term(1'b0, 5'd10, 14'd1);
    vecs[6] = mk_vec(8'd2, 5'd0, 0, -1, 1, 9, 32'hFFFF_FFFD, 1'b0, 2);
    vecs[6].terms[0] = mk_term(1'b1, 5'd0, 14'd5);
    vecs[6].terms[1] = mk_term(1'b0, 5'd0, 14'd2);
    vecs[7] = mk_vec(8'd2, 5'd0, 0, -1, 0, 9, 32'h8000_0003, 1'b0, 2);
    vecs[7].terms[0] = mk_term(1'b0, 5'd31, 14'd1);
    vecs[7].terms[1] = mk_term(1'b0, 5'd0, 14'd3);
    vecs[8] = mk_vec(8'd2, 5'd31, 0, -1, 2, 9, 32'd3, 1'b0, 2);
    vecs[8].terms[0] = mk_term(1'b0, 5'd17, 14'd16383);
    vecs[8].terms[1] = mk_term(1'b0, 5'd31, 14'd3);

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_term_ready", 32'(term_ready), 32'd0);
    checkOutput("reset_acc_start", 32'(acc_start), 32'd0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_res_fixed", res_fixed, 32'd0);
    checkOutput("reset_res_err", 32'(res_err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      dp_lat = 1;
      rand_lat = 1'b0;
      applyStimulus(vecs[i], -1);
      checkVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the second term is in flight, then a clean single-term vector.
    applyStimulus(vecs[0], 2);
    checkOutput("abort_reached", 32'(got_abort), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_term_ready", 32'(term_ready), 32'd0);
    checkOutput("abort_acc_start", 32'(acc_start), 32'd0);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_res_fixed", res_fixed, 32'd0);
    checkOutput("abort_res_exp", 32'(res_exp), 32'd0);
    checkOutput("abort_acc_fixed_acc", acc_fixed_acc, 32'd0);
    checkOutput("abort_acc_exp_in", 32'(acc_exp_in), 32'd0);
    checkOutput("abort_acc_frac_in", 32'(acc_frac_in), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    v = mk_vec(8'd1, 5'd10, 0, -1, 0, 5, 32'd5, 1'b0, 1);
    v.terms[0] = mk_term(1'b0, 5'd10, 14'd5);
    applyStimulus(v, -1);
    checkVector(v, "after_abort");

    rand_lat = 1'b1;
    for (int r = 0; r < 25; r++) begin
      v = '0;
      v.len = 8'($urandom_range(1, 5));
      v.es = 5'($urandom_range(0, 31));
      v.nterms = int'(v.len) + 1;
      for (int k = 0; k < 6; k++) begin
        e = int'(v.es) + int'($urandom_range(0, 12)) - 6;
        if (e < 0) e = 0;
        if (e > 31) e = 31;
        v.terms[k] = mk_term(1'($urandom_range(0, 1)), 5'(e), 14'($urandom));
      end
      v.gap = int'($urandom_range(0, 2));
      v.stuck_at = -1;
      v.rdy_delay = int'($urandom_range(0, 3));
      v.exp_lat = 0;
      acc = '0;
      for (int k = 0; k < int'(v.len); k++)
        acc = acc + term_value(v.terms[k].sign, v.terms[k].exp, v.es, v.terms[k].frac);
      v.exp_fixed = acc;
      v.exp_err = 1'b0;
      v.exp_consumed = int'(v.len);
      applyStimulus(v, -1);
      checkVector(v, $sformatf("rand%0d", r));
    end

    checkOutput("acc_start_single_cycle", pulse_viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
